// File: rtl/glitch_filter_pkg.sv
// rtl/glitch_filter_pkg.sv - shared helpers and channel status type for the glitch filter
package glitch_filter_pkg;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Counter width able to hold 0..maxLen, never narrower than one bit.
    function automatic int cnt_w(input int maxLen);
        int w;
        w = clog2(maxLen + 1);
        return (w < 1) ? 1 : w;
    endfunction

    typedef struct packed {
        logic out;
        logic rise;
        logic fall;
        logic glitch;
    } chan_status_t;

endpackage

// File: rtl/multi_glitch_filter_if.sv
// rtl/multi_glitch_filter_if.sv - control, data and status bundle of the glitch filter
interface multi_glitch_filter_if #(
    parameter int CHANNELS = 8,
    parameter int CNT_W    = 4
);
    logic                en;
    logic [CNT_W-1:0]    filtLen;
    logic                clrGlitch;
    logic [CHANNELS-1:0] inData;
    logic [CHANNELS-1:0] outData;
    logic [CHANNELS-1:0] rise;
    logic [CHANNELS-1:0] fall;
    logic [CHANNELS-1:0] glitch;

    modport master (
        output en,
        output filtLen,
        output clrGlitch,
        output inData,
        input  outData,
        input  rise,
        input  fall,
        input  glitch
    );

    modport slave (
        input  en,
        input  filtLen,
        input  clrGlitch,
        input  inData,
        output outData,
        output rise,
        output fall,
        output glitch
    );
endinterface

// File: rtl/glitch_filter_chan.sv
// rtl/glitch_filter_chan.sv - one filter channel: run counter, filtered level, edge pulses, sticky glitch flag
module glitch_filter_chan
    import glitch_filter_pkg::*;
#(
    parameter int   CNT_W     = 4,
    parameter logic RESET_BIT = 1'b0
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             en,
    input  logic             clrGlitch,
    input  logic [CNT_W-1:0] filtLen,
    input  logic             s,
    output chan_status_t     status
);

    logic             outLvl;
    logic             risePulse;
    logic             fallPulse;
    logic             glitchFlag;
    logic [CNT_W-1:0] cnt;

    logic differ;
    logic qualify;
    logic reject;

    // Using >= lets a run qualify immediately when filtLen is lowered below the count.
    assign differ  = (s != outLvl);
    assign qualify = en & differ & (cnt >= filtLen);
    assign reject  = en & ~differ & (cnt != '0);

    always_ff @(posedge clk) begin
        if (!rstN) begin
            outLvl     <= RESET_BIT;
            cnt        <= '0;
            risePulse  <= 1'b0;
            fallPulse  <= 1'b0;
            glitchFlag <= 1'b0;
        end else begin
            risePulse <= qualify & s;
            fallPulse <= qualify & ~s;
            if (qualify) begin
                outLvl <= s;
            end
            // cnt only increments while below filtLen, which is clamped, so it cannot wrap.
            if (en) begin
                if (!differ || qualify) begin
                    cnt <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
            if (reject) begin
                glitchFlag <= 1'b1;
            end else if (clrGlitch) begin
                glitchFlag <= 1'b0;
            end
        end
    end

    assign status.out    = outLvl;
    assign status.rise   = risePulse;
    assign status.fall   = fallPulse;
    assign status.glitch = glitchFlag;

endmodule

// File: rtl/multi_glitch_filter.sv
// rtl/multi_glitch_filter.sv - multi-channel glitch filter top; GLITCH_FILTER_SYNC_EN adds a 2-flop input synchroniser
module multi_glitch_filter
    import glitch_filter_pkg::*;
#(
    parameter int                  CHANNELS     = 8,
    parameter int                  MAX_FILT_LEN = 15,
    parameter logic [CHANNELS-1:0] RESET_VAL    = '0
) (
    input logic                  clk,
    input logic                  rstN,
    multi_glitch_filter_if.slave bus
);

    localparam int               CNT_W   = cnt_w(MAX_FILT_LEN);
    localparam logic [CNT_W-1:0] MAX_LEN = CNT_W'(MAX_FILT_LEN);

    logic [CNT_W-1:0]    lenClamped;
    logic [CHANNELS-1:0] sData;
    chan_status_t        chanStatus [CHANNELS];

    assign lenClamped = (bus.filtLen > MAX_LEN) ? MAX_LEN : bus.filtLen;

`ifdef GLITCH_FILTER_SYNC_EN
    logic [CHANNELS-1:0] syncMeta;
    logic [CHANNELS-1:0] syncOut;

    // Free-running so the synchronised view stays current while the filter is paused.
    always_ff @(posedge clk) begin
        if (!rstN) begin
            syncMeta <= RESET_VAL;
            syncOut  <= RESET_VAL;
        end else begin
            syncMeta <= bus.inData;
            syncOut  <= syncMeta;
        end
    end

    assign sData = syncOut;
`else
    assign sData = bus.inData;
`endif

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        glitch_filter_chan #(
            .CNT_W    (CNT_W),
            .RESET_BIT(RESET_VAL[i])
        ) u_chan (
            .clk      (clk),
            .rstN     (rstN),
            .en       (bus.en),
            .clrGlitch(bus.clrGlitch),
            .filtLen  (lenClamped),
            .s        (sData[i]),
            .status   (chanStatus[i])
        );

        assign bus.outData[i] = chanStatus[i].out;
        assign bus.rise[i]    = chanStatus[i].rise;
        assign bus.fall[i]    = chanStatus[i].fall;
        assign bus.glitch[i]  = chanStatus[i].glitch;
    end

endmodule
